// File: rtl/score_display_pager_if.sv
// Bus between the game scoring logic and the score display pager.
// Control/data from the master: en (display enable), auto_mode (automatic paging),
// next_pg (single-cycle advance pulse), values (N_PAGES packed VAL_W-bit scores).
// Display/status from the slave: seg_en (one-hot digit select), ctr1/ctr2 (bank active),
// tube1/tube2 (segments {dp,g,f,e,d,c,b,a}), page (current page), busy (converter running).
interface score_display_pager_if #(
    parameter int unsigned N_PAGES = 7,
    parameter int unsigned VAL_W   = 21,
    parameter int unsigned DIGITS  = 8
);
    logic                     en;
    logic                     auto_mode;
    logic                     next_pg;
    logic [N_PAGES*VAL_W-1:0] values;
    logic [DIGITS-1:0]        seg_en;
    logic                     ctr1;
    logic                     ctr2;
    logic [7:0]               tube1;
    logic [7:0]               tube2;
    logic [3:0]               page;
    logic                     busy;

    modport master (
        output en, auto_mode, next_pg, values,
        input  seg_en, ctr1, ctr2, tube1, tube2, page, busy
    );

    modport slave (
        input  en, auto_mode, next_pg, values,
        output seg_en, ctr1, ctr2, tube1, tube2, page, busy
    );
endinterface

// File: rtl/score_display_pager.sv
// Paged score display: holds N_PAGES score values, converts the selected page to decimal
// with a multicycle double-dabble converter and scans it onto two 4-digit tube banks.
// Ports: clk, rst (synchronous, active-high), bus (score_display_pager_if.slave) carrying
// en/auto_mode/next_pg/values in and seg_en/ctr1/ctr2/tube1/tube2/page/busy out.
module score_display_pager #(
    parameter int unsigned N_PAGES      = 7,
    parameter int unsigned VAL_W        = 21,
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned CLK_DIV      = 200000,
    parameter int unsigned DWELL_FRAMES = 125,
    parameter int unsigned SHOW_PAGE    = 1,
    parameter int unsigned LZ_BLANK     = 1
) (
    input logic                  clk,
    input logic                  rst,
    score_display_pager_if.slave bus
);
    localparam int unsigned ND     = DIGITS - SHOW_PAGE;
    // One spare BCD digit above the display width so overflow always has digits to test.
    localparam int unsigned NBCD   = ((VAL_W / 3 + 1) > DIGITS ? (VAL_W / 3 + 1) : DIGITS) + 1;
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned SCAN_W = $clog2(DIGITS);
    localparam int unsigned FC_W   = $clog2(DWELL_FRAMES + 1);
    localparam int unsigned STEP_W = $clog2(VAL_W);

    // Bit 0 of the state doubles as the busy flag.
    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StShift = 2'b01;
    localparam logic [1:0] StLoad  = 2'b11;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // ---------------- scan timebase and paging ----------------
    logic [DIV_W-1:0]  div_cnt_q;
    logic [SCAN_W-1:0] scan_q;
    logic [FC_W-1:0]   frame_cnt_q;
    logic [3:0]        page_q;
    logic              tick;
    logic              frame_end;
    logic              dwell_done;
    logic              page_adv;

    assign tick       = bus.en && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign frame_end  = tick && (scan_q == SCAN_W'(DIGITS - 1));
    assign dwell_done = bus.auto_mode && frame_end &&
                        (frame_cnt_q == FC_W'(DWELL_FRAMES - 1));
    // A manual pulse coinciding with dwell expiry still moves only one page.
    assign page_adv   = bus.next_pg || dwell_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            scan_q    <= '0;
        end else if (!bus.en) begin
            div_cnt_q <= '0;
            scan_q    <= '0;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                scan_q <= frame_end ? '0 : scan_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (!bus.en || !bus.auto_mode || page_adv) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            page_q <= '0;
        end else if (page_adv) begin
            page_q <= (page_q == 4'(N_PAGES - 1)) ? 4'd0 : page_q + 4'd1;
        end
    end

    // ---------------- double-dabble converter ----------------
    logic [1:0]         cv_state_q;
    logic               req_q;
    logic [VAL_W-1:0]   bin_q;
    logic [4*NBCD-1:0]  bcd_q;
    logic [4*NBCD-1:0]  bcd_adj;
    logic [4*NBCD-1:0]  bcd_step;
    logic [STEP_W-1:0]  step_q;
    logic [4*DIGITS-1:0] disp_bcd_q;
    logic               ovf_q;
    logic               start;

    // Page changes always (re)start; frame-end refreshes only when idle.
    assign start = req_q || page_adv || (frame_end && (cv_state_q == StIdle));

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NBCD); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = (bcd_adj << 1) | {{(4*NBCD-1){1'b0}}, bin_q[VAL_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_state_q <= StIdle;
            req_q      <= 1'b1;  // page 0 converts right after reset
            bin_q      <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            disp_bcd_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (start) begin
                cv_state_q <= StLoad;
            end else begin
                case (cv_state_q)
                    StLoad: begin
                        bin_q      <= bus.values[32'(page_q)*VAL_W +: VAL_W];
                        bcd_q      <= '0;
                        step_q     <= '0;
                        cv_state_q <= StShift;
                    end
                    StShift: begin
                        bcd_q  <= bcd_step;
                        bin_q  <= bin_q << 1;
                        step_q <= step_q + 1'b1;
                        // Commit digits and overflow together so the display never tears.
                        if (step_q == STEP_W'(VAL_W - 1)) begin
                            disp_bcd_q <= bcd_step[4*DIGITS-1:0];
                            ovf_q      <= |bcd_step[4*NBCD-1:4*ND];
                            cv_state_q <= StIdle;
                        end
                    end
                    default: cv_state_q <= StIdle;
                endcase
            end
        end
    end

    // ---------------- digit pattern and outputs ----------------
    logic [DIGITS-1:0] blank;
    logic              lz_run;
    logic [3:0]        cur_digit;
    logic [7:0]        pat;
    logic              hi_bank;

    // blank[i] is set when digit i and every value digit above it are zero; digit 0 never blanks.
    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int i = int'(ND) - 1; i >= 1; i--) begin
            lz_run   = lz_run && (disp_bcd_q[4*i +: 4] == 4'd0);
            blank[i] = lz_run && (LZ_BLANK != 0);
        end
    end

    assign cur_digit = disp_bcd_q[{scan_q, 2'b00} +: 4];
    assign hi_bank   = scan_q >= SCAN_W'(DIGITS / 2);

    always_comb begin
        if ((SHOW_PAGE != 0) && (scan_q == SCAN_W'(DIGITS - 1))) begin
            pat = seg7(page_q);
        end else if (ovf_q) begin
            pat = 8'h40;
        end else if (blank[scan_q]) begin
            pat = 8'h00;
        end else begin
            pat = seg7(cur_digit);
        end
    end

    logic [DIGITS-1:0] seg_en_q;
    logic              ctr1_q;
    logic              ctr2_q;
    logic [7:0]        tube1_q;
    logic [7:0]        tube2_q;

    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            seg_en_q <= '0;
            ctr1_q   <= 1'b0;
            ctr2_q   <= 1'b0;
            tube1_q  <= 8'h00;
            tube2_q  <= 8'h00;
        end else begin
            seg_en_q <= DIGITS'(1) << scan_q;
            ctr1_q   <= !hi_bank;
            ctr2_q   <= hi_bank;
            tube1_q  <= hi_bank ? 8'h00 : pat;
            tube2_q  <= hi_bank ? pat : 8'h00;
        end
    end

    assign bus.seg_en = seg_en_q;
    assign bus.ctr1   = ctr1_q;
    assign bus.ctr2   = ctr2_q;
    assign bus.tube1  = tube1_q;
    assign bus.tube2  = tube2_q;
    assign bus.page   = page_q;
    assign bus.busy   = cv_state_q[0];
endmodule

// File: tb/tb_score_display_pager.sv
// Directed bench for score_display_pager: CLK_DIV=4, DIGITS=8, N_PAGES=3, DWELL_FRAMES=2.
// VAL_W=24 so that 10000000 and 9999999 are representable; a conversion then keeps busy
// high for 25 cycles. Cycle numbers below count clock edges from the first edge after reset
// release (edge 0); each edge's outputs are sampled 1 time unit after it.
module tb_score_display_pager;
    localparam int unsigned N_PAGES = 3;
    localparam int unsigned VAL_W   = 24;
    localparam int unsigned DIGITS  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_display_pager_if #(.N_PAGES(N_PAGES), .VAL_W(VAL_W), .DIGITS(DIGITS)) bus ();

    score_display_pager #(
        .N_PAGES(N_PAGES), .VAL_W(VAL_W), .DIGITS(DIGITS), .CLK_DIV(4),
        .DWELL_FRAMES(2), .SHOW_PAGE(1), .LZ_BLANK(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = -100;

    // Frame for page 0 = 1234: digits 0..3 = 4,3,2,1; 4..6 blanked; digit 7 = page 0.
    logic [7:0] exp_1234 [8] = '{8'h66, 8'h4F, 8'h5B, 8'h06, 8'h00, 8'h00, 8'h00, 8'h3F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.auto_mode = 1'b0;
        bus.next_pg   = 1'b0;
        bus.values    = {24'd0, 24'd10000000, 24'd1234};
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_en", bus.seg_en, 0);
        check("rst_tube1", bus.tube1, 0);
        check("rst_tube2", bus.tube2, 0);
        check("rst_page", bus.page, 0);
        check("rst_busy", bus.busy, 0);

        rst    = 1'b0;
        bus.en = 1'b1;
        cyc    = -1;
        goto(0);
        check("e0_busy", bus.busy, 1);
        check("e0_seg_en", bus.seg_en, 8'h01);
        check("e0_ctr1", bus.ctr1, 1);
        check("e0_ctr2", bus.ctr2, 0);
        check("e0_tube1", bus.tube1, 8'h3F);
        check("e0_tube2", bus.tube2, 8'h00);
        goto(24);
        check("conv0_busy_last", bus.busy, 1);
        goto(25);
        check("conv0_busy_done", bus.busy, 0);

        for (int k = 0; k < 8; k++) begin
            goto(32 + 4 * k);
            check("f1234_seg_en", bus.seg_en, 32'(1) << k);
            check("f1234_tube1", bus.tube1, (k < 4) ? exp_1234[k] : 8'h00);
            check("f1234_tube2", bus.tube2, (k < 4) ? 8'h00 : exp_1234[k]);
            check("f1234_ctr1", bus.ctr1, (k < 4) ? 1 : 0);
            check("f1234_ctr2", bus.ctr2, (k < 4) ? 0 : 1);
        end

        // Frame-end conversion starts at edge 63; page change 3 cycles in restarts it.
        goto(65);
        check("abort_busy_before", bus.busy, 1);
        check("abort_page_before", bus.page, 0);
        bus.next_pg = 1'b1;
        goto(66);
        bus.next_pg = 1'b0;
        check("man_page1", bus.page, 1);
        goto(88);
        check("abort_busy_88", bus.busy, 1);
        goto(90);
        check("abort_busy_90", bus.busy, 1);
        goto(91);
        check("abort_busy_91", bus.busy, 0);
        check("abort_old_tube2", bus.tube2, 8'h00);
        goto(92);
        check("p1_page_digit", bus.tube2, 8'h06);
        goto(96);
        check("ovf_d0", bus.tube1, 8'h40);
        goto(100);
        check("ovf_d1", bus.tube1, 8'h40);
        goto(112);
        check("ovf_d4", bus.tube2, 8'h40);

        goto(128);
        bus.next_pg = 1'b1;
        goto(129);
        bus.next_pg = 1'b0;
        check("man_page2", bus.page, 2);
        goto(160);
        check("zero_d0", bus.tube1, 8'h3F);
        goto(164);
        check("zero_d1", bus.tube1, 8'h00);
        goto(184);
        check("zero_d6", bus.tube2, 8'h00);
        goto(188);
        check("p2_page_digit", bus.tube2, 8'h5B);
        goto(192);
        bus.next_pg = 1'b1;
        goto(193);
        bus.next_pg = 1'b0;
        check("man_wrap0", bus.page, 0);

        // Automatic paging: frame ends at edges 223, 255, 287, ...
        goto(200);
        bus.auto_mode = 1'b1;
        goto(254);
        check("auto_hold0", bus.page, 0);
        goto(255);
        check("auto_page1", bus.page, 1);
        check("auto_busy_start", bus.busy, 1);
        goto(279);
        check("auto_busy_last", bus.busy, 1);
        goto(280);
        check("auto_busy_done", bus.busy, 0);
        goto(318);
        check("auto_hold1", bus.page, 1);
        goto(319);
        check("auto_page2", bus.page, 2);
        goto(330);
        bus.values[23:0] = 24'd9999999;
        goto(382);
        check("auto_hold2", bus.page, 2);
        goto(383);
        check("auto_wrap0", bus.page, 0);
        goto(416);
        check("nines_d0", bus.tube1, 8'h6F);
        goto(428);
        check("nines_d3", bus.tube1, 8'h6F);
        goto(432);
        check("nines_d4", bus.tube2, 8'h6F);
        goto(440);
        check("nines_d6", bus.tube2, 8'h6F);
        goto(444);
        check("nines_page_digit", bus.tube2, 8'h3F);

        // Manual pulse on the dwell-expiry edge 447: single increment.
        goto(446);
        check("coinc_before", bus.page, 0);
        bus.next_pg = 1'b1;
        goto(447);
        bus.next_pg = 1'b0;
        check("coinc_single", bus.page, 1);
        goto(510);
        check("coinc_hold", bus.page, 1);
        goto(511);
        check("coinc_next_auto", bus.page, 2);

        // Disable mid-scan; conversion started at 511 still completes.
        goto(520);
        check("pre_dis_seg_en", bus.seg_en, 8'h04);
        bus.en = 1'b0;
        goto(521);
        check("dis_seg_en", bus.seg_en, 0);
        check("dis_tube1", bus.tube1, 0);
        check("dis_tube2", bus.tube2, 0);
        check("dis_ctr1", bus.ctr1, 0);
        check("dis_page", bus.page, 2);
        goto(535);
        check("dis_conv_busy", bus.busy, 1);
        goto(536);
        check("dis_conv_done", bus.busy, 0);
        goto(539);
        bus.next_pg = 1'b1;
        goto(540);
        bus.next_pg = 1'b0;
        check("dis_next_pg", bus.page, 0);
        goto(545);
        bus.en = 1'b1;
        goto(546);
        check("reen_seg_en", bus.seg_en, 8'h01);
        goto(547);
        bus.next_pg = 1'b1;
        goto(548);
        bus.next_pg = 1'b0;
        check("pre_rst_page", bus.page, 1);
        check("pre_rst_busy", bus.busy, 1);

        // Reset in the middle of a conversion.
        goto(551);
        rst = 1'b1;
        goto(552);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_page", bus.page, 0);
        check("mid_rst_seg_en", bus.seg_en, 0);
        check("mid_rst_tube1", bus.tube1, 0);
        check("mid_rst_tube2", bus.tube2, 0);
        rst = 1'b0;
        goto(553);
        check("post_rst_busy", bus.busy, 1);
        check("post_rst_seg_en", bus.seg_en, 8'h01);
        check("post_rst_tube1", bus.tube1, 8'h3F);
        goto(577);
        check("post_rst_busy_last", bus.busy, 1);
        goto(578);
        check("post_rst_busy_done", bus.busy, 0);
        goto(585);
        check("post_rst_d0", bus.tube1, 8'h6F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
